// File: rtl/psx_pkg.sv
// Shared PSX link constants, state encoding and reply-byte mapping.
// Imported by both the console and the controller side of the link.
package psx_pkg;

  localparam logic [7:0] START_CMD    = 8'h01;
  localparam logic [7:0] BEGIN_TX_CMD = 8'h42;
  localparam logic [7:0] NO_OP        = 8'h00;
  localparam logic [7:0] ID_ANALOG    = 8'h73;
  localparam logic [7:0] PREAMBLE     = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ACK_WAIT,
    ST_ACK_PULSE,
    ST_IGNORE
  } psx_state_e;

  function automatic logic [7:0] rev8(
    input logic [7:0] v
  );
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [7:0] tx_byte(
    input logic [3:0]  idx,
    input logic [15:0] btn,
    input logic [31:0] stk
  );
    logic [7:0] b;
    case (idx)
      4'd1:    b = ID_ANALOG;
      4'd2:    b = PREAMBLE;
      4'd3:    b = rev8(btn[15:8]);
      4'd4:    b = rev8(btn[7:0]);
      4'd5:    b = stk[31:24];
      4'd6:    b = stk[23:16];
      4'd7:    b = stk[15:8];
      4'd8:    b = stk[7:0];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/psx_controller_if.sv
// Poll-link and pad-state bundle between a host and the controller.
// master = host/console side, slave = emulated controller.
interface psx_controller_if;

  logic        att;
  logic        psx_clk;
  logic        cmd;
  logic [15:0] button_state;
  logic [31:0] stick_state;
  logic        data;
  logic        ack;
  logic        polled;

  modport master (
    output att, psx_clk, cmd,
    output button_state, stick_state,
    input  data, ack, polled
  );

  modport slave (
    input  att, psx_clk, cmd,
    input  button_state, stick_state,
    output data, ack, polled
  );

endinterface

// File: rtl/psx_sync.sv
// Two-flop synchroniser with rise/fall strobes on the synced level.
// Strobes stay masked until the chain holds only real pin samples.
module psx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sh;
  logic [2:0] r_vld;

  // shift the pin through the chain; fill the valid mask after reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh  <= {3{RST_VAL}};
      r_vld <= '0;
    end else begin
      r_sh  <= {r_sh[1:0], i_d};
      r_vld <= {r_vld[1:0], 1'b1};
    end
  end

  assign o_q    = r_sh[1];
  assign o_rise = r_vld[2] & r_sh[1] & ~r_sh[2];
  assign o_fall = r_vld[2] & ~r_sh[1] & r_sh[2];

endmodule

// File: rtl/psx_controller.sv
// Device-side PSX pad: answers 0x01/0x42 polls with an analog
// (0x73) reply built from a snapshot taken at att fall.
import psx_pkg::*;

module psx_controller #(
  parameter int ACK_DELAY = 500,
  parameter int ACK_WIDTH = 100
) (
  input logic             clk,
  input logic             rst,
  psx_controller_if.slave io_psx
);

  localparam int CNT_MAX =
    (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int CW = $clog2(CNT_MAX + 1);

  logic w_unused_att;
  logic w_att_rise, w_att_fall;
  logic w_unused_pclk;
  logic w_pclk_rise, w_pclk_fall;
  logic w_cmd;
  logic w_unused_cmd_rise, w_unused_cmd_fall;

  psx_sync #(.RST_VAL(1'b1)) u_att (
    .i_clk (clk), .i_rst (rst), .i_d (io_psx.att),
    .o_q (w_unused_att),
    .o_rise (w_att_rise), .o_fall (w_att_fall)
  );

  psx_sync #(.RST_VAL(1'b1)) u_pclk (
    .i_clk (clk), .i_rst (rst), .i_d (io_psx.psx_clk),
    .o_q (w_unused_pclk),
    .o_rise (w_pclk_rise), .o_fall (w_pclk_fall)
  );

  psx_sync #(.RST_VAL(1'b1)) u_cmd (
    .i_clk (clk), .i_rst (rst), .i_d (io_psx.cmd),
    .o_q (w_cmd),
    .o_rise (w_unused_cmd_rise), .o_fall (w_unused_cmd_fall)
  );

  psx_state_e      r_state, w_nxt_state;
  logic [3:0]      r_byte, w_nxt_byte;
  logic [2:0]      r_bit, w_nxt_bit;
  logic [7:0]      r_rx, w_nxt_rx, w_rx_full;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic [15:0]     r_btn, w_nxt_btn;
  logic [31:0]     r_stk, w_nxt_stk;
  logic            r_data, w_nxt_data;
  logic            r_ack, w_nxt_ack;
  logic            r_polled, w_nxt_polled;
  logic [7:0]      w_tx;

  assign w_tx = tx_byte(r_byte, r_btn, r_stk);

  // received byte including the bit arriving on this edge
  always_comb begin
    w_rx_full = r_rx;
    w_rx_full[r_bit] = w_cmd;
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_byte   <= '0;
      r_bit    <= '0;
      r_rx     <= NO_OP;
      r_cnt    <= '0;
      r_btn    <= 16'hFFFF;
      r_stk    <= 32'h8080_8080;
      r_data   <= 1'b1;
      r_ack    <= 1'b1;
      r_polled <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_byte   <= w_nxt_byte;
      r_bit    <= w_nxt_bit;
      r_rx     <= w_nxt_rx;
      r_cnt    <= w_nxt_cnt;
      r_btn    <= w_nxt_btn;
      r_stk    <= w_nxt_stk;
      r_data   <= w_nxt_data;
      r_ack    <= w_nxt_ack;
      r_polled <= w_nxt_polled;
    end
  end

  // next state and outputs; att release overrides everything
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_byte   = r_byte;
    w_nxt_bit    = r_bit;
    w_nxt_rx     = r_rx;
    w_nxt_cnt    = r_cnt;
    w_nxt_btn    = r_btn;
    w_nxt_stk    = r_stk;
    w_nxt_data   = r_data;
    w_nxt_ack    = r_ack;
    w_nxt_polled = 1'b0;
    if (w_att_rise) begin
      w_nxt_state = ST_IDLE;
      w_nxt_data  = 1'b1;
      w_nxt_ack   = 1'b1;
      w_nxt_byte  = '0;
      w_nxt_bit   = '0;
      w_nxt_cnt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_att_fall) begin
            w_nxt_btn   = io_psx.button_state;
            w_nxt_stk   = io_psx.stick_state;
            w_nxt_byte  = '0;
            w_nxt_bit   = '0;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_pclk_fall) begin
            w_nxt_data = w_tx[r_bit];
          end else if (w_pclk_rise) begin
            w_nxt_rx = w_rx_full;
            if (r_bit != 3'd7) begin
              w_nxt_bit = r_bit + 3'd1;
            end else if ((r_byte == 4'd0 &&
                          w_rx_full != START_CMD) ||
                         (r_byte == 4'd1 &&
                          w_rx_full != BEGIN_TX_CMD)) begin
              w_nxt_data  = 1'b1;
              w_nxt_state = ST_IGNORE;
            end else if (r_byte == 4'd8) begin
              w_nxt_polled = 1'b1;
              w_nxt_data   = 1'b1;
              w_nxt_state  = ST_IGNORE;
            end else begin
              w_nxt_byte  = r_byte + 4'd1;
              w_nxt_bit   = '0;
              w_nxt_cnt   = '0;
              w_nxt_state = ST_ACK_WAIT;
            end
          end
        end
        ST_ACK_WAIT, ST_ACK_PULSE: begin
          if (w_pclk_fall) begin
            w_nxt_ack   = 1'b1;
            w_nxt_data  = w_tx[0];
            w_nxt_cnt   = '0;
            w_nxt_state = ST_SHIFT;
          end else if (r_state == ST_ACK_WAIT &&
                       r_cnt == CW'(ACK_DELAY - 1)) begin
            w_nxt_ack   = 1'b0;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_ACK_PULSE;
          end else if (r_state == ST_ACK_PULSE &&
                       r_cnt == CW'(ACK_WIDTH - 1)) begin
            w_nxt_ack   = 1'b1;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_SHIFT;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
        ST_IGNORE: begin
          w_nxt_data = 1'b1;
          w_nxt_ack  = 1'b1;
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  assign io_psx.data   = r_data;
  assign io_psx.ack    = r_ack;
  assign io_psx.polled = r_polled;

endmodule

// File: tb/tb_psx_controller.sv
// Host-side bench for psx_controller: polls it over the serial link
// and checks every reply byte, ack pulse and polled strobe.
module tb_psx_controller;

  localparam int D = 40;
  localparam int W = 12;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  psx_controller_if ifc ();

  psx_controller #(.ACK_DELAY(D), .ACK_WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_psx (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_polled = 0;
  int att_hi = 0;
  bit mon_en = 1'b0;
  logic prev_p = 1'b0;
  logic [7:0] got [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // reply byte k for a given pad snapshot, from the bit-mapping rules
  function automatic logic [7:0] model(input int k,
                                       input logic [15:0] b,
                                       input logic [31:0] s);
    int v;
    v = 0;
    case (k)
      0: v = 255;
      1: v = 'h73;
      2: v = 'h5A;
      3: for (int i = 0; i < 8; i++) v += int'(b[15-i]) << i;
      4: for (int i = 0; i < 8; i++) v += int'(b[7-i]) << i;
      default: v = int'((s >> (8 * (8 - k))) & 32'hFF);
    endcase
    return v[7:0];
  endfunction

  // idle-line and polled-strobe monitor, every cycle
  always @(negedge clk) begin
    if (ifc.polled === 1'b1) begin
      n_polled++;
      chk("polled_1cyc", {31'd0, prev_p}, 0);
    end
    prev_p = ifc.polled;
    if (mon_en) begin
      if (ifc.att) att_hi++;
      else att_hi = 0;
      if (att_hi >= 4)
        chk("idle_lines", {ifc.data, ifc.ack, ifc.polled}, 3'b110);
    end
  end

  // one host transaction; abort_at / rst_at name the byte where it stops
  task automatic xfer(input logic [7:0] c0, input logic [7:0] c1,
                      input bit early, input int abort_at,
                      input int rst_at, input bit chg);
    logic [15:0] sb;
    logic [31:0] ss;
    logic [7:0]  cb, r, e;
    bit v, ackx, aborted;
    int p0, n, m;
    sb = ifc.button_state;
    ss = ifc.stick_state;
    v = (c0 == 8'h01) && (c1 == 8'h42);
    aborted = 1'b0;
    p0 = n_polled;
    ifc.att = 1'b0;
    step(6);
    if (chg) begin
      ifc.button_state = 16'($urandom);
      ifc.stick_state = $urandom;
    end
    for (int k = 0; k < 9 && !aborted; k++) begin
      cb = (k == 0) ? c0 : (k == 1) ? c1 : 8'($urandom);
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
        ifc.psx_clk = 1'b0;
        ifc.cmd = cb[i];
        step(H);
        if (k == rst_at && i == 4) begin
          rst = 1'b1;
          #1;
          chk("rst_async", {ifc.data, ifc.ack}, 2'b11);
          step(3);
          rst = 1'b0;
          ifc.psx_clk = 1'b1;
          step(4);
          n = 0;
          repeat (8) begin
            ifc.psx_clk = 1'b0;
            step(H);
            if (ifc.data !== 1'b1 || ifc.ack !== 1'b1) n++;
            ifc.psx_clk = 1'b1;
            step(H);
          end
          chk("post_rst_quiet", n, 0);
          ifc.att = 1'b1;
          step(6);
          chk("rst_no_poll", n_polled - p0, 0);
          return;
        end
        r[i] = ifc.data;
        ifc.psx_clk = 1'b1;
        if (i < 7) step(H);
      end
      got[k] = r;
      if (k == 0) e = 8'hFF;
      else if (k == 1) e = (c0 == 8'h01) ? 8'h73 : 8'hFF;
      else e = v ? model(k, sb, ss) : 8'hFF;
      chk($sformatf("byte%0d", k), r, e);
      ackx = (k == 0) ? (c0 == 8'h01) : (k < 8 && v);
      if (ackx && !early) begin
        n = 0;
        while (ifc.ack === 1'b1 && n < D + 20) begin
          step(1);
          n++;
        end
        chk("ack_delay", n, D + 3);
        if (k == abort_at) begin
          ifc.att = 1'b1;
          step(3);
          chk("abort_lines", {ifc.data, ifc.ack}, 2'b11);
          aborted = 1'b1;
        end else begin
          m = 0;
          while (ifc.ack === 1'b0 && m < W + 20) begin
            step(1);
            m++;
          end
          chk("ack_width", m, W);
          step(H);
        end
      end else if (!ackx) begin
        n = 0;
        repeat (D + W + 8) begin
          step(1);
          if (ifc.ack !== 1'b1) n++;
        end
        chk("no_ack", n, 0);
      end else begin
        step(H);
        chk("early_no_ack", {31'd0, ifc.ack}, 1);
      end
    end
    ifc.psx_clk = 1'b1;
    ifc.att = 1'b1;
    step(6);
    chk("polled_cnt", n_polled - p0,
        (v && !aborted) ? 1 : 0);
  endtask

  initial begin
    int na;
    logic [7:0] c0, c1;
    bit er;
    ifc.att = 1'b1;
    ifc.psx_clk = 1'b1;
    ifc.cmd = 1'b1;
    ifc.button_state = 16'hFFFF;
    ifc.stick_state = 32'h8080_8080;
    rst = 1'b1;
    step(3);
    chk("rst_lines", {ifc.data, ifc.ack, ifc.polled}, 3'b110);
    rst = 1'b0;
    mon_en = 1'b1;
    step(5);

    chk("model_b3", model(3, 16'hFFFE, 0), 8'hFF);
    chk("model_b4", model(4, 16'hFFFE, 0), 8'h7F);
    chk("model_b6", model(6, 0, 32'h12345678), 8'h34);

    ifc.button_state = 16'hFFFE;
    ifc.stick_state = 32'h1234_5678;
    step(4);
    xfer(8'h01, 8'h42, 1'b0, -1, -1, 1'b1);
    chk("lit_id", got[1], 8'h73);
    chk("lit_pre", got[2], 8'h5A);
    chk("lit_btn2", got[4], 8'h7F);
    chk("lit_rx", got[5], 8'h12);
    chk("lit_ly", got[8], 8'h78);

    xfer(8'h81, 8'h42, 1'b0, -1, -1, 1'b0);
    xfer(8'h01, 8'h42, 1'b0, -1, -1, 1'b0);
    xfer(8'h01, 8'h43, 1'b0, -1, -1, 1'b0);
    xfer(8'h01, 8'h42, 1'b0, 3, -1, 1'b0);
    xfer(8'h01, 8'h42, 1'b1, -1, -1, 1'b1);

    ifc.button_state = 16'h0000;
    step(4);
    xfer(8'h01, 8'h42, 1'b0, -1, 3, 1'b0);
    ifc.button_state = 16'h5AA5;
    ifc.stick_state = 32'h80FF_0001;
    step(4);
    xfer(8'h01, 8'h42, 1'b0, -1, -1, 1'b0);
    chk("lit_btn1", got[3], 8'h5A);
    chk("lit_ry", got[6], 8'hFF);

    for (int it = 0; it < 20; it++) begin
      ifc.button_state = 16'($urandom);
      ifc.stick_state = $urandom;
      step(4);
      c0 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h01;
      c1 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h42;
      er = ($urandom_range(0, 2) == 0);
      na = (!er && $urandom_range(0, 3) == 0) ?
           $urandom_range(0, 7) : -1;
      xfer(c0, c1, er, na, -1, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

endmodule
